queue_calc_param: RTL and testbench

//  Parametrised next-generation queue calculator: circular FIFO of DEPTH operands of WIDTH bits

---
 rtl/queue_calc_pkg.sv | 33 +++
 rtl/seq_divider.sv | 57 +++++
 rtl/queue_calc_param.sv | 168 ++++++++++++++++
 tb/tb_queue_calc_param.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_calc_pkg.sv
// rtl/queue_calc_pkg.sv - shared opcode, error-code and FSM state types for the queue calculator
package queue_calc_pkg;

    typedef enum logic [2:0] {
        OP_PUSH    = 3'd0,
        OP_POP     = 3'd1,
        OP_ADD     = 3'd2,
        OP_SUB     = 3'd3,
        OP_MUL     = 3'd4,
        OP_DIV     = 3'd5,
        OP_MOD     = 3'd6,
        OP_CLR_ERR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_DIV0      = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        DIVIDE = 2'd2
    } state_e;

    // Binary ops consume the two oldest entries and append one result.
    function automatic logic is_binary(input op_e o);
        return (o != OP_PUSH) && (o != OP_POP) && (o != OP_CLR_ERR);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - WIDTH-cycle unsigned restoring divider
// Ports: clk, rst_n (async active-low), start (load a/b, begin), a (dividend), b (divisor),
//        busy (stepping), done (final step this cycle; quot/rem valid from next cycle), quot, rem.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   trial;

    // quot doubles as the dividend shift register; its MSB feeds the partial remainder.
    // A set MSB in trial means the subtraction borrowed, so the remainder is restored.
    assign trial = {rem, quot[WIDTH-1]} - {1'b0, divisor};
    assign done  = busy && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            cnt     <= '0;
            divisor <= '0;
            quot    <= '0;
            rem     <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= CNT_W'(WIDTH);
            divisor <= b;
            quot    <= a;
            rem     <= '0;
        end else if (busy) begin
            if (!trial[WIDTH]) begin
                rem  <= trial[WIDTH-1:0];
                quot <= {quot[WIDTH-2:0], 1'b1};
            end else begin
                rem  <= {rem[WIDTH-2:0], quot[WIDTH-1]};
                quot <= {quot[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/queue_calc_param.sv
// rtl/queue_calc_param.sv - circular operand queue with multi-cycle ALU and sticky error codes
// Ports: clk, rst (async active-low), in (PUSH value), op (opcode), apply (strobe, taken with ready),
//        ready (idle), tail/head (newest/oldest, 0 when empty), count (occupancy), empty, full,
//        res_valid (1-cycle pulse with new ALU result at tail), err (sticky), err_code.
module queue_calc_param
    import queue_calc_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       op,
    input  logic             apply,
    output logic             ready,
    output logic [WIDTH-1:0] tail,
    output logic [WIDTH-1:0] head,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             res_valid,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_TWO = (PTR_W + 1)'(2);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_TWO = PTR_W'(2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rptr, wptr;
    state_e           state;
    op_e              cmd, op_q;
    logic [WIDTH-1:0] rd_a, rd_b, a_q, b_q, alu_res, quot, rem;
    logic             do_cmd, is_div, bin_ok, push_wr, div_start, div_busy, div_done;

    assign cmd  = op_e'(op);
    assign rd_a = mem[rptr];
    assign rd_b = mem[rptr + PTR_ONE];

    assign ready = (state == IDLE) && !div_busy;
    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);
    assign head  = empty ? '0 : rd_a;
    assign tail  = empty ? '0 : mem[wptr - PTR_ONE];

    // While an error is pending only CLR_ERR has any effect.
    assign do_cmd    = apply && ready && (!err || cmd == OP_CLR_ERR);
    assign is_div    = (cmd == OP_DIV) || (cmd == OP_MOD);
    assign bin_ok    = do_cmd && is_binary(cmd) && (count >= CNT_TWO) && !(is_div && rd_b == '0);
    assign div_start = bin_ok && is_div;
    assign push_wr   = do_cmd && (cmd == OP_PUSH) && !full;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk   (clk),
        .rst_n (rst),
        .start (div_start),
        .a     (rd_a),
        .b     (rd_b),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (quot),
        .rem   (rem)
    );

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_MUL:  alu_res = a_q * b_q;
            OP_DIV:  alu_res = quot;
            OP_MOD:  alu_res = rem;
            default: alu_res = '0;
        endcase
    end

    // Storage has no reset; contents behind the pointers are don't-care.
    always_ff @(posedge clk) begin
        if (push_wr) begin
            mem[wptr] <= in;
        end else if (state == EXEC) begin
            mem[wptr] <= alu_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            res_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_PUSH;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_cmd) begin
                        case (cmd)
                            OP_PUSH: begin
                                if (full) begin
                                    err      <= 1'b1;
                                    err_code <= ERR_OVERFLOW;
                                end else begin
                                    wptr  <= wptr + PTR_ONE;
                                    count <= count + CNT_ONE;
                                end
                            end
                            OP_POP: begin
                                if (empty) begin
                                    err      <= 1'b1;
                                    err_code <= ERR_UNDERFLOW;
                                end else begin
                                    rptr  <= rptr + PTR_ONE;
                                    count <= count - CNT_ONE;
                                end
                            end
                            OP_CLR_ERR: begin
                                err      <= 1'b0;
                                err_code <= ERR_NONE;
                            end
                            default: begin
                                // Underflow is checked before divide-by-zero.
                                if (count < CNT_TWO) begin
                                    err      <= 1'b1;
                                    err_code <= ERR_UNDERFLOW;
                                end else if (is_div && rd_b == '0) begin
                                    err      <= 1'b1;
                                    err_code <= ERR_DIV0;
                                end else begin
                                    a_q   <= rd_a;
                                    b_q   <= rd_b;
                                    op_q  <= cmd;
                                    rptr  <= rptr + PTR_TWO;
                                    count <= count - CNT_TWO;
                                    state <= is_div ? DIVIDE : EXEC;
                                end
                            end
                        endcase
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Two entries were freed at accept, so this push cannot overflow.
                    wptr      <= wptr + PTR_ONE;
                    count     <= count + CNT_ONE;
                    res_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_queue_calc_param.sv
// tb/tb_queue_calc_param.sv - self-checking bench for queue_calc_param (WIDTH=8, DEPTH=4)
module tb_queue_calc_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    localparam logic [2:0] C_PUSH = 3'd0, C_POP = 3'd1, C_ADD = 3'd2, C_SUB = 3'd3;
    localparam logic [2:0] C_MUL  = 3'd4, C_DIV = 3'd5, C_MOD = 3'd6, C_CLR = 3'd7;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic [2:0]       op;
    logic             apply;
    logic             ready, empty, full, res_valid, err;
    logic [WIDTH-1:0] tail, head;
    logic [2:0]       count;
    logic [1:0]       err_code;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] sb [$];

    typedef struct {
        logic [2:0] op;
        logic [7:0] din;
        bit         has_res;
        logic [7:0] res;
        int         cnt;
        int         head;
        int         tail;
        int         err;
        int         code;
        int         busy;
    } vec_t;

    vec_t vecs [$];

    queue_calc_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .op        (op),
        .apply     (apply),
        .ready     (ready),
        .tail      (tail),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .res_valid (res_valid),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [2:0] o, input int d, input bit h, input int r,
                                input int c, input int hd, input int tl, input int e,
                                input int cd, input int b);
        vec_t v;
        v.op = o; v.din = 8'(d); v.has_res = h; v.res = 8'(r);
        v.cnt = c; v.head = hd; v.tail = tl; v.err = e; v.code = cd; v.busy = b;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // Starts at a negedge with ready=1; returns at the first negedge where ready is back.
    task automatic do_cmd(input logic [2:0] o, input logic [7:0] v, output int busy);
        int  guard;
        bit  fin;
        logic [WIDTH-1:0] e;
        busy  = 0;
        guard = 0;
        fin   = 0;
        op    = o;
        din   = v;
        apply = 1'b1;
        @(posedge clk);
        #1;
        apply = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (res_valid) begin
                check("result_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result_tail", int'(tail), int'(e));
                end
            end
            if (ready) begin
                fin = 1;
            end else begin
                busy++;
                guard++;
                if (guard > 50) begin
                    check("ready_timeout", 0, 1);
                    fin = 1;
                end
            end
        end
    endtask

    initial begin
        int  b;
        int  guard;
        bit  fin;
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] e;

        rst = 1'b0; apply = 1'b0; op = C_PUSH; din = '0;

        vecs.push_back(mk(C_PUSH,   5, 0,   0, 1,   5,   5, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,   3, 0,   0, 2,   5,   3, 0, 0, 0));
        vecs.push_back(mk(C_SUB,    0, 1,   2, 1,   2,   2, 0, 0, 1));
        vecs.push_back(mk(C_PUSH,   3, 0,   0, 2,   2,   3, 0, 0, 0));
        vecs.push_back(mk(C_SUB,    0, 1, 255, 1, 255, 255, 0, 0, 1));
        vecs.push_back(mk(C_POP,    0, 0,   0, 0,   0,   0, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,  16, 0,   0, 1,  16,  16, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,  32, 0,   0, 2,  16,  32, 0, 0, 0));
        vecs.push_back(mk(C_MUL,    0, 1,   0, 1,   0,   0, 0, 0, 1));
        vecs.push_back(mk(C_POP,    0, 0,   0, 0,   0,   0, 0, 0, 0));
        vecs.push_back(mk(C_PUSH, 100, 0,   0, 1, 100, 100, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,   7, 0,   0, 2, 100,   7, 0, 0, 0));
        vecs.push_back(mk(C_DIV,    0, 1,  14, 1,  14,  14, 0, 0, 9));
        vecs.push_back(mk(C_POP,    0, 0,   0, 0,   0,   0, 0, 0, 0));
        vecs.push_back(mk(C_PUSH, 100, 0,   0, 1, 100, 100, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,   7, 0,   0, 2, 100,   7, 0, 0, 0));
        vecs.push_back(mk(C_MOD,    0, 1,   2, 1,   2,   2, 0, 0, 9));
        vecs.push_back(mk(C_POP,    0, 0,   0, 0,   0,   0, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,   1, 0,   0, 1,   1,   1, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,   2, 0,   0, 2,   1,   2, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,   3, 0,   0, 3,   1,   3, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,   4, 0,   0, 4,   1,   4, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,   5, 0,   0, 4,   1,   4, 1, 2, 0));
        vecs.push_back(mk(C_PUSH,   6, 0,   0, 4,   1,   4, 1, 2, 0));
        vecs.push_back(mk(C_ADD,    0, 0,   0, 4,   1,   4, 1, 2, 0));
        vecs.push_back(mk(C_CLR,    0, 0,   0, 4,   1,   4, 0, 0, 0));
        vecs.push_back(mk(C_ADD,    0, 1,   3, 3,   3,   3, 0, 0, 1));
        vecs.push_back(mk(C_POP,    0, 0,   0, 2,   4,   3, 0, 0, 0));
        vecs.push_back(mk(C_POP,    0, 0,   0, 1,   3,   3, 0, 0, 0));
        vecs.push_back(mk(C_POP,    0, 0,   0, 0,   0,   0, 0, 0, 0));
        vecs.push_back(mk(C_POP,    0, 0,   0, 0,   0,   0, 1, 1, 0));
        vecs.push_back(mk(C_CLR,    0, 0,   0, 0,   0,   0, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,   9, 0,   0, 1,   9,   9, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,   0, 0,   0, 2,   9,   0, 0, 0, 0));
        vecs.push_back(mk(C_DIV,    0, 0,   0, 2,   9,   0, 1, 3, 0));
        vecs.push_back(mk(C_ADD,    0, 0,   0, 2,   9,   0, 1, 3, 0));
        vecs.push_back(mk(C_CLR,    0, 0,   0, 2,   9,   0, 0, 0, 0));
        vecs.push_back(mk(C_ADD,    0, 1,   9, 1,   9,   9, 0, 0, 1));
        vecs.push_back(mk(C_POP,    0, 0,   0, 0,   0,   0, 0, 0, 0));
        vecs.push_back(mk(C_ADD,    0, 0,   0, 0,   0,   0, 1, 1, 0));
        vecs.push_back(mk(C_CLR,    0, 0,   0, 0,   0,   0, 0, 0, 0));
        vecs.push_back(mk(C_PUSH,   7, 0,   0, 1,   7,   7, 0, 0, 0));
        vecs.push_back(mk(C_MOD,    0, 0,   0, 1,   7,   7, 1, 1, 0));
        vecs.push_back(mk(C_CLR,    0, 0,   0, 1,   7,   7, 0, 0, 0));
        vecs.push_back(mk(C_POP,    0, 0,   0, 0,   0,   0, 0, 0, 0));

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_err", int'(err), 0);
        check("rst_code", int'(err_code), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_head", int'(head), 0);
        check("rst_tail", int'(tail), 0);
        rst = 1'b1;
        @(negedge clk);

        // Reset in the middle of a divide aborts it
        do_cmd(C_PUSH, 8'd200, b);
        do_cmd(C_PUSH, 8'd7, b);
        op = C_DIV; apply = 1'b1;
        @(posedge clk);
        #1;
        apply = 1'b0;
        repeat (3) @(negedge clk);
        check("middiv_busy", int'(ready), 0);
        rst = 1'b0;
        #1;
        check("middiv_count", int'(count), 0);
        check("middiv_ready", int'(ready), 1);
        check("middiv_err", int'(err), 0);
        check("middiv_res_valid", int'(res_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("middiv_no_late_result", int'(res_valid), 0);
        check("middiv_count_after", int'(count), 0);

        // Table of single commands
        foreach (vecs[i]) begin
            if (vecs[i].has_res) sb.push_back(vecs[i].res);
            do_cmd(vecs[i].op, vecs[i].din, b);
            check($sformatf("v%0d_busy", i), b, vecs[i].busy);
            check($sformatf("v%0d_count", i), int'(count), vecs[i].cnt);
            check($sformatf("v%0d_head", i), int'(head), vecs[i].head);
            check($sformatf("v%0d_tail", i), int'(tail), vecs[i].tail);
            check($sformatf("v%0d_err", i), int'(err), vecs[i].err);
            check($sformatf("v%0d_code", i), int'(err_code), vecs[i].code);
            check($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].cnt == 0));
            check($sformatf("v%0d_full", i), int'(full), int'(vecs[i].cnt == DEPTH));
            check($sformatf("v%0d_sb_drained", i), sb.size(), 0);
        end

        // Pointer wrap: alternating PUSH/POP walks both pointers around the ring
        for (int k = 0; k < 10; k++) begin
            v = 8'($urandom_range(1, 255));
            do_cmd(C_PUSH, v, b);
            check($sformatf("wrap%0d_head", k), int'(head), int'(v));
            check($sformatf("wrap%0d_tail", k), int'(tail), int'(v));
            check($sformatf("wrap%0d_count", k), int'(count), 1);
            do_cmd(C_POP, 8'd0, b);
            check($sformatf("wrap%0d_count_pop", k), int'(count), 0);
        end

        // apply held high through DIVIDE: nothing else is executed until ready returns
        do_cmd(C_PUSH, 8'd50, b);
        do_cmd(C_PUSH, 8'd5, b);
        sb.push_back(8'd10);
        op = C_DIV; din = '0; apply = 1'b1;
        @(posedge clk);
        #1;
        op = C_PUSH; din = 8'd77;
        b = 0; guard = 0; fin = 0;
        while (!fin) begin
            @(negedge clk);
            if (res_valid) begin
                check("held_result_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("held_result_tail", int'(tail), int'(e));
                end
            end
            if (ready) begin
                apply = 1'b0;
                fin = 1;
            end else begin
                b++;
                guard++;
                if (guard > 50) begin
                    check("held_ready_timeout", 0, 1);
                    apply = 1'b0;
                    fin = 1;
                end
            end
        end
        check("held_busy", b, 9);
        check("held_count", int'(count), 1);
        check("held_tail", int'(tail), 10);
        check("held_sb_drained", sb.size(), 0);
        @(negedge clk);
        check("held_count_after", int'(count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
